// File: rtl/timer_device.sv
// timer_device -- memory-mapped countdown timer on the CPU data bus.
//
// Register map (word offsets from BASE_ADDR, decoded on addr[31:4]):
//   +0x0  CTRL   {28'b0, IM[3], MODE[2:1], EN[0]}
//   +0x4  PRESET reload value (CNT_W bits, zero-extended on read)
//   +0x8  COUNT  current count, read-only
//   +0xC  reads 0, writes ignored
//
// MODE 2'b01 auto-reloads and pulses irq for one cycle per period; any other
// MODE is one-shot (EN clears itself and irq stays high until CTRL is written).
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-low reset
//   addr    in   32-bit byte address from the CPU data port
//   byteen  in   byte write enables; any bit set marks a write cycle
//   wdata   in   write data
//   rdata   out  read data, combinational from addr
//   irq     out  registered interrupt request (int_flag & IM)
//
// Build option: define TIMER_BYTE_WRITE_EN to let each byteen bit update only
// its own byte of CTRL/PRESET. Left undefined, only byteen==4'b1111 writes.

module timer_device #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic             irq_q;

    logic        hit;
    logic        wr_go;
    logic [31:0] bmask;
    logic        ctrl_wr;
    logic        preset_wr;
    logic [3:0]  ctrl_wval;
    logic [31:0] preset_wval;
    logic        unused_addr;

    // Byte offset within the word is irrelevant to the word-wide registers.
    assign unused_addr = ^addr[1:0];

    assign hit = (addr[31:4] == BASE_ADDR[31:4]);

`ifdef TIMER_BYTE_WRITE_EN
    assign wr_go = hit && (byteen != 4'b0000);
    assign bmask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
`else
    assign wr_go = hit && (byteen == 4'b1111);
    assign bmask = '1;
`endif

    assign ctrl_wr   = wr_go && (addr[3:2] == 2'd0);
    assign preset_wr = wr_go && (addr[3:2] == 2'd1);

    // Merge enabled bytes over the current contents; CTRL keeps only bits [3:0].
    assign ctrl_wval   = (ctrl_q & ~bmask[3:0]) | (wdata[3:0] & bmask[3:0]);
    assign preset_wval = (32'(preset_q) & ~bmask) | (wdata & bmask);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q == '0) begin
                    state_d = S_INT;
                    flag_d  = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            S_INT: begin
                if (ctrl_q[2:1] == 2'b01) begin
                    flag_d  = 1'b0;
                    state_d = ctrl_q[0] ? S_LOAD : S_IDLE;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes are applied last so a CPU CTRL write overrides the
        // FSM's self-clear of EN and any flag update on the same edge.
        if (ctrl_wr) begin
            ctrl_d = ctrl_wval;
            flag_d = 1'b0;
        end
        if (preset_wr) begin
            preset_d = CNT_W'(preset_wval);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= flag_d & ctrl_d[3];
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            unique case (addr[3:2])
                2'd0:    rdata = {28'b0, ctrl_q};
                2'd1:    rdata = 32'(preset_q);
                2'd2:    rdata = 32'(count_q);
                default: rdata = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_device.sv
module tb_timer_device;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL  = BASE + 32'h0;
    localparam logic [31:0] A_PRE   = BASE + 32'h4;
    localparam logic [31:0] A_CNT   = BASE + 32'h8;
    localparam logic [31:0] A_RSV   = BASE + 32'hC;
    localparam logic [31:0] A_OUT   = BASE + 32'h10;

`ifdef TIMER_BYTE_WRITE_EN
    localparam bit BM = 1'b1;
`else
    localparam bit BM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    timer_device #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr   = a;
        byteen = be;
        wdata  = d;
        tick();
        byteen = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr   = a;
        byteen = '0;
        #1;
        v = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Expected behaviour t edges after the CTRL write that sets EN, starting
    // from COUNT=0: load two edges in, period N+3, INT seen on edge N+3.
    task automatic model(input int n, input int mode, input int im, input int t,
                         output logic e_irq, output logic [31:0] e_cnt,
                         output logic [31:0] e_ctrl);
        int  per;
        int  p;
        bit  auto_m;
        bit  fired;
        bit  en;
        logic [1:0] m2;
        per    = n + 3;
        auto_m = (mode == 1);
        if (auto_m) fired = (t >= per) && (((t - per) % per) == 0);
        else        fired = (t >= per);
        e_irq = (im != 0) && fired;
        if (t < 2) begin
            e_cnt = 0;
        end else begin
            p = auto_m ? ((t - 2) % per) : (t - 2);
            e_cnt = (p <= n) ? 32'(n - p) : 32'd0;
        end
        en = auto_m ? 1'b1 : (t < per + 1);
        m2 = 2'(mode);
        e_ctrl = {28'b0, (im != 0), m2, en};
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] p_after;
        logic        e_irq;
        logic [31:0] e_cnt, e_ctrl;
        bit          reached;

        // Test 1: reset held for 3 cycles
        reset = 1'b0;
        tick(); tick(); tick();
        rd(A_CTRL, v); chk("reset_ctrl", v, 32'h0);
        rd(A_PRE, v);  chk("reset_preset", v, 32'h0);
        rd(A_CNT, v);  chk("reset_count", v, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset = 1'b1;
        tick();

        // Register access table (timer never enabled here)
        p_after = BM ? 32'hAB34_56FF : 32'h1234_5678;
        vecs[0]  = '{"pre_full",    A_PRE,  4'hF, 32'h1234_5678, A_PRE,  32'h1234_5678};
        vecs[1]  = '{"pre_byte0",   A_PRE,  4'h1, 32'h0000_00FF, A_PRE,  BM ? 32'h1234_56FF : 32'h1234_5678};
        vecs[2]  = '{"pre_byte3",   A_PRE,  4'h8, 32'hAB00_0000, A_PRE,  p_after};
        vecs[3]  = '{"ctrl_hibits", A_CTRL, 4'hF, 32'hFFFF_FFF6, A_CTRL, 32'h6};
        vecs[4]  = '{"count_ro",    A_CNT,  4'hF, 32'h0000_AAAA, A_CNT,  32'h0};
        vecs[5]  = '{"rsv_word",    A_RSV,  4'hF, 32'h0000_0055, A_RSV,  32'h0};
        vecs[6]  = '{"out_nowr",    A_OUT,  4'hF, 32'h0000_0077, A_PRE,  p_after};
        vecs[7]  = '{"out_read",    A_OUT,  4'hF, 32'h0000_0077, A_OUT,  32'h0};
        vecs[8]  = '{"ctrl_byte1",  A_CTRL, 4'h2, 32'h0000_0100, A_CTRL, 32'h6};
        vecs[9]  = '{"ctrl_byte0",  A_CTRL, 4'h1, 32'h0000_0000, A_CTRL, BM ? 32'h0 : 32'h6};
        vecs[10] = '{"ctrl_clear",  A_CTRL, 4'hF, 32'h0000_0000, A_CTRL, 32'h0};
        vecs[11] = '{"pre_unalign", BASE + 32'h6, 4'hF, 32'h0, A_PRE, 32'h0};
        for (int i = 0; i < 12; i++) begin
            wr(vecs[i].waddr, vecs[i].be, vecs[i].wd);
            rd(vecs[i].raddr, v);
            chk(vecs[i].name, v, vecs[i].exp);
        end

        // Test 2: one-shot, PRESET=5, irq from E0+8 and held
        do_reset();
        wr(A_PRE, 4'hF, 32'd5);
        wr(A_CTRL, 4'hF, 32'h9);
        for (int t = 0; t <= 10; t++) begin
            chk($sformatf("oneshot_irq_t%0d", t), 32'(irq), (t >= 8) ? 32'h1 : 32'h0);
            tick();
        end
        rd(A_CTRL, v); chk("oneshot_ctrl", v, 32'h8);
        wr(A_CTRL, 4'hF, 32'h0);
        chk("oneshot_clear_irq", 32'(irq), 32'h0);

        // Test 3: auto-reload, PRESET=2
        do_reset();
        wr(A_PRE, 4'hF, 32'd2);
        wr(A_CTRL, 4'hF, 32'hB);
        for (int t = 0; t < 20; t++) begin
            model(2, 1, 1, t, e_irq, e_cnt, e_ctrl);
            chk($sformatf("auto_irq_t%0d", t), 32'(irq), 32'(e_irq));
            rd(A_CNT, v);
            chk($sformatf("auto_cnt_t%0d", t), v, e_cnt);
            tick();
        end
        wr(A_CTRL, 4'hF, 32'h0);

        // Test 4: disable mid-count freezes COUNT, re-enable reloads
        do_reset();
        wr(A_PRE, 4'hF, 32'd100);
        wr(A_CTRL, 4'hF, 32'h9);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            rd(A_CNT, v);
            if (v == 32'd40) reached = 1'b1;
            else tick();
        end
        chk("freeze_reach40", 32'(reached), 32'h1);
        wr(A_CTRL, 4'hF, 32'h8);
        tick(); tick(); tick();
        rd(A_CNT, v);
        chk("freeze_cnt_39_or_40", v, (v == 32'd40) ? 32'd40 : 32'd39);
        tick();
        rd(A_CNT, e_cnt);
        chk("freeze_stable", e_cnt, v);
        chk("freeze_irq", 32'(irq), 32'h0);
        wr(A_CTRL, 4'hF, 32'h9);
        tick(); tick();
        rd(A_CNT, v);
        chk("reload_100", v, 32'd100);

        // Test 6: reset mid-count
        wr(A_PRE, 4'hF, 32'd50);
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rd(A_CTRL, v); chk("midrst_ctrl", v, 32'h0);
        rd(A_PRE, v);  chk("midrst_preset", v, 32'h0);
        rd(A_CNT, v);  chk("midrst_count", v, 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("midrst_irq_later", 32'(irq), 32'h0);

        // Randomized enable trials against the arithmetic model
        for (int trial = 0; trial < 25; trial++) begin
            int n, mode, im, tmax;
            n    = int'($urandom_range(0, 12));
            mode = int'($urandom_range(0, 3));
            im   = int'($urandom_range(0, 1));
            tmax = 2 * (n + 3) + 4;
            do_reset();
            wr(A_PRE, 4'hF, 32'(n));
            wr(A_CTRL, 4'hF, {28'b0, 1'(im), 2'(mode), 1'b1});
            for (int t = 0; t <= tmax; t++) begin
                model(n, mode, im, t, e_irq, e_cnt, e_ctrl);
                chk($sformatf("rnd%0d_irq_t%0d", trial, t), 32'(irq), 32'(e_irq));
                rd(A_CNT, v);
                chk($sformatf("rnd%0d_cnt_t%0d", trial, t), v, e_cnt);
                rd(A_CTRL, v);
                chk($sformatf("rnd%0d_ctrl_t%0d", trial, t), v, e_ctrl);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
